// File: rtl/iob_fifo_pkg.sv
// Shared FIFO helpers: depth/level-width functions and flag reset values.
// Used by iob_regfile_fifo_ctrl and its pointer sub-module.
package iob_fifo_pkg;

  function automatic int DEPTH(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic int LEVEL_W(input int addr_w);
    return addr_w + 1;
  endfunction

  localparam logic FULL_RST   = 1'b0;
  localparam logic EMPTY_RST  = 1'b1;
  localparam logic AFULL_RST  = 1'b0;
  localparam logic AEMPTY_RST = 1'b1;

endpackage

// File: rtl/iob_fifo_ptr.sv
// ADDR_W-bit wrapping pointer with enable, clock enable and synchronous reset.
module iob_fifo_ptr #(
  parameter int ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cke_i,
  input  logic              en_i,
  output logic [ADDR_W-1:0] ptr_o
);

  // Natural ADDR_W-bit overflow gives the wrap from 2**ADDR_W-1 to 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_o <= '0;
    end else if (cke_i && en_i) begin
      ptr_o <= ptr_o + 1'b1;
    end
  end

endmodule

// File: rtl/iob_regfile_fifo_ctrl.sv
// FIFO controller in front of a 1W/1R register file with async read; pop data is registered.
// Optional almost-full/almost-empty flags are enabled with IOB_REGFILE_FIFO_CTRL_THRESH_EN.
module iob_regfile_fifo_ctrl
  import iob_fifo_pkg::*;
#(
  parameter int ADDR_W    = 3,
`ifdef IOB_REGFILE_FIFO_CTRL_THRESH_EN
  parameter int AFULL_TH  = 2**ADDR_W - 1,
  parameter int AEMPTY_TH = 1,
`endif
  parameter int DATA_W    = 21
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cke_i,
  input  logic                       w_en_i,
  input  logic [DATA_W-1:0]          w_data_i,
  output logic                       w_full_o,
  input  logic                       r_en_i,
  output logic [DATA_W-1:0]          r_data_o,
  output logic                       r_empty_o,
  output logic [LEVEL_W(ADDR_W)-1:0] level_o,
  output logic                       overflow_o,
  output logic                       underflow_o,
`ifdef IOB_REGFILE_FIFO_CTRL_THRESH_EN
  output logic                       almost_full_o,
  output logic                       almost_empty_o,
`endif
  output logic                       ext_mem_wen_o,
  output logic [ADDR_W-1:0]          ext_mem_waddr_o,
  output logic [DATA_W-1:0]          ext_mem_wdata_o,
  output logic [ADDR_W-1:0]          ext_mem_raddr_o,
  input  logic [DATA_W-1:0]          ext_mem_rdata_i
);

  localparam int              LW       = LEVEL_W(ADDR_W);
  localparam logic [LW-1:0]   FULL_LVL = LW'(DEPTH(ADDR_W));

  logic [LW-1:0]     level_q;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic              push;
  logic              pop;

  // Handshake: a request is taken in any cycle with cke_i high, its enable high and
  // its flag (full/empty from the level register) low; there is no other backpressure.
  assign w_full_o  = (level_q == FULL_LVL);
  assign r_empty_o = (level_q == '0);
  assign push      = !rst_i && cke_i && w_en_i && !w_full_o;
  assign pop       = !rst_i && cke_i && r_en_i && !r_empty_o;
  assign level_o   = level_q;

  assign ext_mem_wen_o   = push;
  assign ext_mem_waddr_o = wptr;
  assign ext_mem_wdata_o = w_data_i;
  assign ext_mem_raddr_o = rptr;

  iob_fifo_ptr #(.ADDR_W(ADDR_W)) u_wptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .cke_i (cke_i),
    .en_i  (push),
    .ptr_o (wptr)
  );

  iob_fifo_ptr #(.ADDR_W(ADDR_W)) u_rptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .cke_i (cke_i),
    .en_i  (pop),
    .ptr_o (rptr)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q     <= '0;
      r_data_o    <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (cke_i) begin
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (pop) begin
        r_data_o <= ext_mem_rdata_i;
      end
      overflow_o  <= w_en_i && w_full_o;
      underflow_o <= r_en_i && r_empty_o;
    end else begin
      // Pulses must not stretch across a stalled cycle.
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end
  end

`ifdef IOB_REGFILE_FIFO_CTRL_THRESH_EN
  // Level resets to 0, which yields AFULL_RST / AEMPTY_RST on these flags.
  assign almost_full_o  = (level_q >= LW'(AFULL_TH));
  assign almost_empty_o = (level_q <= LW'(AEMPTY_TH));
`endif

endmodule

// File: tb/tb_iob_regfile_fifo_ctrl.sv
// Directed bench for iob_regfile_fifo_ctrl (ADDR_W=2) with a behavioural register file.
module tb_iob_regfile_fifo_ctrl;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 21;
  localparam int LW     = ADDR_W + 1;

  logic              clk;
  logic              rst;
  logic              cke;
  logic              w_en;
  logic [DATA_W-1:0] w_data;
  logic              w_full;
  logic              r_en;
  logic [DATA_W-1:0] r_data;
  logic              r_empty;
  logic [LW-1:0]     level;
  logic              overflow;
  logic              underflow;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] mem [4];
  logic [DATA_W-1:0] exp_q [$];

  int total;
  int bad;

  iob_regfile_fifo_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .cke_i           (cke),
    .w_en_i          (w_en),
    .w_data_i        (w_data),
    .w_full_o        (w_full),
    .r_en_i          (r_en),
    .r_data_o        (r_data),
    .r_empty_o       (r_empty),
    .level_o         (level),
    .overflow_o      (overflow),
    .underflow_o     (underflow),
    .ext_mem_wen_o   (mem_wen),
    .ext_mem_waddr_o (mem_waddr),
    .ext_mem_wdata_o (mem_wdata),
    .ext_mem_raddr_o (mem_raddr),
    .ext_mem_rdata_i (mem_rdata)
  );

  // Clock and register file model.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wen) mem[mem_waddr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_raddr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks: inputs change 1ns after the edge, outputs are read 1ns after.
  task automatic drive(input logic r, input logic c, input logic we, input logic re,
                       input logic [DATA_W-1:0] d);
    rst = r; cke = c; w_en = we; r_en = re; w_data = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pop_check_post(input string tag, input int e_lvl, input logic e_full,
                                     input logic e_empty, input logic e_ov, input logic e_un);
    chk({tag, "_level"}, 32'(level), 32'(e_lvl));
    chk({tag, "_full"}, 32'(w_full), 32'(e_full));
    chk({tag, "_empty"}, 32'(r_empty), 32'(e_empty));
    chk({tag, "_ovf"}, 32'(overflow), 32'(e_ov));
    chk({tag, "_unf"}, 32'(underflow), 32'(e_un));
  endtask

  typedef struct {
    logic              rst, cke, wen, ren;
    logic [DATA_W-1:0] wdata;
    logic              e_wen;
    logic [ADDR_W-1:0] e_waddr, e_raddr;
    int                e_level;
    logic              e_full, e_empty;
    logic [DATA_W-1:0] e_rdata;
    logic              e_ov, e_un;
  } vec_t;

  function automatic vec_t mk(logic r, logic c, logic we, logic re, logic [DATA_W-1:0] d,
                              logic ewen, logic [ADDR_W-1:0] ewa, logic [ADDR_W-1:0] era,
                              int el, logic ef, logic ee, logic [DATA_W-1:0] erd,
                              logic eov, logic eun);
    vec_t v;
    v.rst = r; v.cke = c; v.wen = we; v.ren = re; v.wdata = d;
    v.e_wen = ewen; v.e_waddr = ewa; v.e_raddr = era; v.e_level = el;
    v.e_full = ef; v.e_empty = ee; v.e_rdata = erd; v.e_ov = eov; v.e_un = eun;
    return v;
  endfunction

  vec_t vecs [15];

  initial begin
    int wp;
    int rp;
    logic [DATA_W-1:0] val;
    logic [DATA_W-1:0] exp_d;

    total = 0;
    bad   = 0;

    //                rst cke we re data     wen wa ra  lvl full emp rdata ov un
    vecs[0]  = mk(0, 1, 0, 0, 'h00, 0, 0, 0, 0, 0, 1, 'h00, 0, 0);
    vecs[1]  = mk(0, 1, 1, 0, 'h11, 1, 0, 0, 1, 0, 0, 'h00, 0, 0);
    vecs[2]  = mk(0, 1, 1, 0, 'h22, 1, 1, 0, 2, 0, 0, 'h00, 0, 0);
    vecs[3]  = mk(0, 1, 1, 0, 'h33, 1, 2, 0, 3, 0, 0, 'h00, 0, 0);
    vecs[4]  = mk(0, 1, 1, 0, 'h44, 1, 3, 0, 4, 1, 0, 'h00, 0, 0);
    vecs[5]  = mk(0, 1, 1, 0, 'h55, 0, 0, 0, 4, 1, 0, 'h00, 1, 0);
    vecs[6]  = mk(0, 1, 0, 0, 'h00, 0, 0, 0, 4, 1, 0, 'h00, 0, 0);
    vecs[7]  = mk(0, 1, 0, 1, 'h00, 0, 0, 0, 3, 0, 0, 'h11, 0, 0);
    vecs[8]  = mk(0, 1, 0, 1, 'h00, 0, 0, 1, 2, 0, 0, 'h22, 0, 0);
    vecs[9]  = mk(0, 1, 0, 1, 'h00, 0, 0, 2, 1, 0, 0, 'h33, 0, 0);
    vecs[10] = mk(0, 1, 0, 1, 'h00, 0, 0, 3, 0, 0, 1, 'h44, 0, 0);
    vecs[11] = mk(0, 1, 0, 1, 'h00, 0, 0, 0, 0, 0, 1, 'h44, 0, 1);
    vecs[12] = mk(0, 1, 0, 0, 'h00, 0, 0, 0, 0, 0, 1, 'h44, 0, 0);
    vecs[13] = mk(0, 1, 1, 1, 'h66, 1, 0, 0, 1, 0, 0, 'h44, 0, 1);
    vecs[14] = mk(0, 1, 0, 0, 'h00, 0, 1, 0, 1, 0, 0, 'h44, 0, 0);

    // Reset block.
    drive(1, 1, 0, 0, '0);
    tick();
    tick();

    for (int i = 0; i < 15; i++) begin
      string t;
      t = $sformatf("v%0d", i);
      drive(vecs[i].rst, vecs[i].cke, vecs[i].wen, vecs[i].ren, vecs[i].wdata);
      chk({t, "_wen"}, 32'(mem_wen), 32'(vecs[i].e_wen));
      chk({t, "_waddr"}, 32'(mem_waddr), 32'(vecs[i].e_waddr));
      chk({t, "_raddr"}, 32'(mem_raddr), 32'(vecs[i].e_raddr));
      if (vecs[i].e_wen) chk({t, "_wdata"}, 32'(mem_wdata), 32'(vecs[i].wdata));
      tick();
      push_pop_check_post(t, vecs[i].e_level, vecs[i].e_full, vecs[i].e_empty,
                          vecs[i].e_ov, vecs[i].e_un);
      chk({t, "_rdata"}, 32'(r_data), 32'(vecs[i].e_rdata));
    end

    // Drain the 0x66 left by the push-while-empty vector.
    drive(0, 1, 0, 1, '0);
    tick();
    chk("drain_rdata", 32'(r_data), 32'h66);
    push_pop_check_post("drain", 0, 0, 1, 0, 0);

    // Wrap-around: six push/pop pairs, pointers start at 1 and cross 3 -> 0.
    wp  = 1;
    rp  = 1;
    val = 'h100;
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 1, 0, val);
      chk($sformatf("wrap%0d_waddr", i), 32'(mem_waddr), 32'(wp));
      chk($sformatf("wrap%0d_wen", i), 32'(mem_wen), 32'd1);
      tick();
      exp_q.push_back(val);
      wp  = (wp + 1) % 4;
      val = val + 'h11;
      drive(0, 1, 0, 1, '0);
      chk($sformatf("wrap%0d_raddr", i), 32'(mem_raddr), 32'(rp));
      tick();
      rp = (rp + 1) % 4;
      exp_d = exp_q.pop_front();
      chk($sformatf("wrap%0d_rdata", i), 32'(r_data), 32'(exp_d));
      chk($sformatf("wrap%0d_level", i), 32'(level), 32'd0);
    end

    // Simultaneous push and pop at level 2, then at level 4 (full).
    drive(0, 1, 1, 0, 'h0a1); tick(); exp_q.push_back('h0a1);
    drive(0, 1, 1, 0, 'h0b2); tick(); exp_q.push_back('h0b2);
    drive(0, 1, 1, 1, 'h0c3);
    chk("mid_wen", 32'(mem_wen), 32'd1);
    tick();
    exp_q.push_back('h0c3);
    exp_d = exp_q.pop_front();
    chk("mid_rdata", 32'(r_data), 32'(exp_d));
    push_pop_check_post("mid", 2, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 'h0d4); tick(); exp_q.push_back('h0d4);
    drive(0, 1, 1, 0, 'h0e5); tick(); exp_q.push_back('h0e5);
    push_pop_check_post("fill", 4, 1, 0, 0, 0);
    drive(0, 1, 1, 1, 'h0f6);
    chk("fullboth_wen", 32'(mem_wen), 32'd0);
    tick();
    exp_d = exp_q.pop_front();
    chk("fullboth_rdata", 32'(r_data), 32'(exp_d));
    push_pop_check_post("fullboth", 3, 0, 0, 1, 0);

    // Reset at level 3 with a concurrent push.
    drive(1, 1, 1, 0, 'h1ff);
    chk("rst_wen", 32'(mem_wen), 32'd0);
    tick();
    exp_q.delete();
    push_pop_check_post("rst", 0, 0, 1, 0, 0);
    chk("rst_rdata", 32'(r_data), 32'd0);
    chk("rst_raddr", 32'(mem_raddr), 32'd0);

    // Clock enable low with both requests active: nothing moves.
    drive(0, 1, 1, 0, 'h077); tick();
    drive(0, 1, 1, 0, 'h078); tick();
    drive(0, 0, 1, 1, 'h079);
    chk("cke0_wen", 32'(mem_wen), 32'd0);
    tick();
    tick();
    push_pop_check_post("cke0", 2, 0, 0, 0, 0);
    chk("cke0_rdata", 32'(r_data), 32'd0);
    chk("cke0_raddr", 32'(mem_raddr), 32'd0);
    chk("cke0_waddr", 32'(mem_waddr), 32'd2);
    drive(0, 1, 0, 1, '0);
    tick();
    chk("cke1_rdata", 32'(r_data), 32'h077);
    chk("cke1_level", 32'(level), 32'd1);

    drive(0, 1, 0, 0, '0);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
